// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults and FSM state codes for the MAC round-robin scheduler.
package mac_pkg;
    localparam int DEF_N_REQ = 4;
    localparam int DEF_VEC_LEN = 8;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_ACC_W = 11;
    localparam int DEF_RES_TIMEOUT = 8;
    localparam logic [2:0] SYNC = 3'd0;
    localparam logic [2:0] ARB = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] WAIT_RES = 3'd3;
    localparam logic [2:0] RETURN = 3'd4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr.
module rr_arbiter #(
    parameter int N = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);
    logic [IW:0] s;
    // Scan from the farthest candidate back to ptr so the nearest set request wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        s = '0;
        for (int k = N - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (IW + 1)'(k);
            s = (s >= (IW + 1)'(N)) ? s - (IW + 1)'(N) : s;
            if (req[s[IW-1:0]]) begin
                any = 1'b1;
                idx = s[IW-1:0];
            end
        end
        onehot = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/mac_rr_scheduler.sv
// mac_rr_scheduler: round-robin sharing of one MAC; streams a job's operand pairs and returns the tagged result.
module mac_rr_scheduler
    import mac_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int VEC_LEN = DEF_VEC_LEN,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int RES_TIMEOUT = DEF_RES_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_a,
    input  logic [N_REQ*DATA_W-1:0]    req_b,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           grant,
    output logic [DATA_W-1:0]          mac_a,
    output logic [DATA_W-1:0]          mac_b,
    output logic                       mac_valid,
    output logic                       mac_rst,
    input  logic [ACC_W-1:0]           mac_out,
    input  logic                       mac_out_valid,
    output logic [ACC_W-1:0]           res_data,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    output logic                       res_valid,
    output logic                       timeout_err
);
    localparam int IW = $clog2(N_REQ);
    localparam int BW = $clog2(VEC_LEN);
    localparam int TW = $clog2(RES_TIMEOUT + 1);

    logic [2:0]       state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    owner;
    logic [BW-1:0]    beat_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic             win_any;
    logic [N_REQ-1:0] win;
    logic [IW-1:0]    win_idx;
    logic             beat;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req(req),
        .ptr(rr_ptr),
        .any(win_any),
        .onehot(win),
        .idx(win_idx)
    );

    assign req_ready = (state == STREAM) ? grant & req_valid : '0;
    assign beat = (state == STREAM) && req_valid[owner];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SYNC;
            rr_ptr <= '0;
            owner <= '0;
            beat_cnt <= '0;
            tmo_cnt <= '0;
            grant <= '0;
            mac_a <= '0;
            mac_b <= '0;
            mac_valid <= 1'b0;
            mac_rst <= 1'b1;
            res_data <= '0;
            res_id <= '0;
            res_valid <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                SYNC: begin
                    mac_rst <= 1'b0;
                    state <= ARB;
                end
                ARB: begin
                    if (win_any) begin
                        grant <= win;
                        owner <= win_idx;
                        beat_cnt <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    mac_valid <= beat;
                    if (beat) begin
                        mac_a <= req_a[owner*DATA_W +: DATA_W];
                        mac_b <= req_b[owner*DATA_W +: DATA_W];
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == BW'(VEC_LEN - 1)) begin
                            tmo_cnt <= '0;
                            state <= WAIT_RES;
                        end
                    end
                end
                WAIT_RES: begin
                    mac_valid <= 1'b0;
                    if (mac_out_valid) begin
                        res_data <= mac_out;
                        res_id <= owner;
                        res_valid <= 1'b1;
                        state <= RETURN;
                    end else if (tmo_cnt == TW'(RES_TIMEOUT)) begin
                        // Abort: clear the MAC and hand back a zero result so the owner is released.
                        timeout_err <= 1'b1;
                        mac_rst <= 1'b1;
                        res_data <= '0;
                        res_id <= owner;
                        res_valid <= 1'b1;
                        state <= RETURN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RETURN: begin
                    res_valid <= 1'b0;
                    mac_rst <= 1'b0;
                    grant <= '0;
                    rr_ptr <= (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                    state <= ARB;
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_rr_scheduler.sv
// tb_mac_rr_scheduler: directed jobs against a transaction-level model of round-robin grants and dot-product results.
module tb_mac_rr_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req, req_valid, req_ready, grant;
    logic [15:0] req_a, req_b;
    logic [3:0]  mac_a, mac_b;
    logic        mac_valid, mac_rst, mac_out_valid;
    logic [10:0] mac_out, res_data;
    logic [1:0]  res_id;
    logic        res_valid, timeout_err;

    mac_rr_scheduler dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .req_valid(req_valid), .req_ready(req_ready), .grant(grant),
        .mac_a(mac_a), .mac_b(mac_b), .mac_valid(mac_valid), .mac_rst(mac_rst),
        .mac_out(mac_out), .mac_out_valid(mac_out_valid), .res_data(res_data),
        .res_id(res_id), .res_valid(res_valid), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic signed [3:0] ja[4][8];
    logic signed [3:0] jb[4][8];
    int pos[4];
    bit job[4];
    int stall_id = -1;
    int stall_after = 0;
    int stall_left = 0;
    bit withhold = 1'b0;
    logic [3:0] rdy;
    typedef struct {int id; int data;} res_t;
    res_t log_q[$];
    int grant_log[$];

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bit st;
            st = (i == stall_id) && (pos[i] == stall_after) && (stall_left > 0);
            if (st) stall_left--;
            req[i] = job[i] && pos[i] < 8;
            req_valid[i] = job[i] && pos[i] < 8 && !st;
            req_a[i*4 +: 4] = ja[i][pos[i] < 8 ? pos[i] : 7];
            req_b[i*4 +: 4] = jb[i][pos[i] < 8 ? pos[i] : 7];
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (rdy[i]) pos[i]++;
        drive();
    endtask

    task automatic set_job(int i, int a, int b);
        for (int k = 0; k < 8; k++) begin
            ja[i][k] = 4'(a);
            jb[i][k] = 4'(b);
        end
        pos[i] = 0;
        job[i] = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            job[i] = 1'b0;
            pos[i] = 0;
        end
        stall_id = -1;
        drive();
        cyc();
        cyc();
        reset = 1'b0;
        drive();
    endtask

    task automatic wait_jobs(int n, int budget);
        int t = 0;
        while (log_q.size() < n && t < budget) begin
            cyc();
            t++;
        end
        if (log_q.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_res: got %0d results expected %0d", log_q.size(), n);
        end
    endtask

    task automatic chk_res(string name, int idx, int id, int data);
        if (idx < log_q.size()) begin
            chk({name, "_id"}, log_q[idx].id, id);
            chk({name, "_data"}, log_q[idx].data, data);
        end else chk({name, "_missing"}, log_q.size(), idx + 1);
    endtask

    task automatic chk_grant(string name, int idx, int id);
        if (idx < grant_log.size()) chk(name, grant_log[idx], id);
        else chk({name, "_missing"}, grant_log.size(), idx + 1);
    endtask

    // MAC model: sums 8 products, presents the result two cycles after the last beat.
    initial begin
        int acc, n, cd;
        acc = 0; n = 0; cd = 0;
        mac_out = '0;
        mac_out_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mac_out_valid = 1'b0;
            if (mac_rst) begin
                acc = 0; n = 0; cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        mac_out = 11'(acc);
                        mac_out_valid = !withhold;
                        acc = 0;
                        n = 0;
                    end
                end
                if (mac_valid) begin
                    acc += int'($signed(mac_a)) * int'($signed(mac_b));
                    n++;
                    if (n == 8) cd = 2;
                end
            end
        end
    end

    function automatic int rr_pick(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic int job_sum(int o);
        int s = 0;
        for (int k = 0; k < 8; k++) s += int'(ja[o][k]) * int'(jb[o][k]);
        return s;
    endfunction

    logic [3:0] p_req = '0, p_rdy = '0, p_grant = '0;
    bit p_reset = 1'b1, p_res = 1'b0, tmo_flag = 1'b0;
    int owner = -1, beats = 0, mptr = 0, pick, expv;

    always @(negedge clk) begin
        if (p_reset) begin
            chk("reset_state",
                int'({grant, mac_valid, res_valid, mac_rst, timeout_err, res_id, mac_a, mac_b, res_data}),
                int'({4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b0, 4'b0, 4'b0, 11'b0}));
            owner = -1; beats = 0; mptr = 0; tmo_flag = 1'b0;
        end else begin
            if (p_rdy != 0) begin
                chk("mac_valid_beat", int'(mac_valid), 1);
                if (owner >= 0 && beats < 8) begin
                    chk("mac_a", int'($signed(mac_a)), int'(ja[owner][beats]));
                    chk("mac_b", int'($signed(mac_b)), int'(jb[owner][beats]));
                end
                beats++;
            end else chk("mac_valid_idle", int'(mac_valid), 0);
            chk("ready_in_grant", int'(req_ready & ~grant), 0);
            chk("grant_onehot0", int'($onehot0(grant)), 1);
            if (p_res) begin
                chk("grant_drop", int'(grant), 0);
                chk("res_one_cycle", int'(res_valid), 0);
            end else if (p_grant == 0 && grant != 0) begin
                pick = rr_pick(p_req, mptr);
                chk("grant_rr", int'(grant), pick < 0 ? 0 : (1 << pick));
                owner = pick;
                beats = 0;
                grant_log.push_back(pick);
            end else if (p_grant != 0) chk("grant_hold", int'(grant), int'(p_grant));
            if (res_valid) begin
                chk("res_owner_known", int'(owner >= 0), 1);
                if (owner >= 0) begin
                    expv = withhold ? 0 : job_sum(owner);
                    chk("res_id", int'(res_id), owner);
                    chk("res_data", int'($signed(res_data)), expv);
                    chk("res_beats", beats, 8);
                    if (withhold) tmo_flag = 1'b1;
                    log_q.push_back('{owner, int'($signed(res_data))});
                    mptr = (owner + 1) % 4;
                end
            end
            chk("timeout_err", int'(timeout_err), int'(tmo_flag));
            chk("mac_rst", int'(mac_rst), int'(res_valid && withhold));
        end
        p_reset = reset;
        p_req = req;
        p_rdy = reset ? 4'b0 : req_ready;
        p_grant = grant;
        p_res = res_valid;
    end

    initial begin
        int b, g, t;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 8; k++) begin
                ja[i][k] = '0;
                jb[i][k] = '0;
            end
            pos[i] = 0;
            job[i] = 1'b0;
        end
        drive();
        do_reset();
        // single requester, back-to-back beats
        b = log_q.size(); g = grant_log.size();
        set_job(0, 3, 2);
        wait_jobs(b + 1, 100);
        chk_res("t1", b, 0, 48);
        chk_grant("t1_grant", g, 0);
        // all four requesting: strict rotation from a fresh pointer
        do_reset();
        b = log_q.size(); g = grant_log.size();
        for (int i = 0; i < 4; i++) set_job(i, 1, -1);
        wait_jobs(b + 4, 400);
        for (int i = 0; i < 4; i++) begin
            chk_grant("t2_grant", g + i, i);
            chk_res("t2", b + i, i, -8);
        end
        // owner stalls three cycles after beat 4
        b = log_q.size();
        set_job(2, 0, 2);
        for (int k = 0; k < 8; k++) ja[2][k] = 4'(k - 3);
        stall_id = 2; stall_after = 4; stall_left = 3;
        drive();
        wait_jobs(b + 1, 100);
        chk_res("t3", b, 2, 8);
        stall_id = -1;
        // MAC never answers: abort path, then the next job still runs
        b = log_q.size();
        withhold = 1'b1;
        set_job(1, 1, 1);
        wait_jobs(b + 1, 100);
        chk_res("t4_tmo", b, 1, 0);
        chk("t4_timeout_err", int'(timeout_err), 1);
        withhold = 1'b0;
        set_job(3, 2, -3);
        wait_jobs(b + 2, 100);
        chk_res("t4_next", b + 1, 3, -48);
        chk("t4_sticky", int'(timeout_err), 1);
        // reset in the middle of a job
        do_reset();
        set_job(0, 1, 1);
        t = 0;
        while (pos[0] < 5 && t < 50) begin
            cyc();
            t++;
        end
        chk("t5_reach_beat5", pos[0], 5);
        reset = 1'b1;
        job[0] = 1'b0;
        drive();
        cyc();
        chk("t5_grant", int'(grant), 0);
        chk("t5_mac_valid", int'(mac_valid), 0);
        chk("t5_mac_rst", int'(mac_rst), 1);
        reset = 1'b0;
        pos[0] = 0;
        drive();
        b = log_q.size();
        repeat (20) cyc();
        chk("t5_no_result", log_q.size(), b);
        // extreme operands
        set_job(0, -8, -8);
        wait_jobs(b + 1, 100);
        chk_res("t6_max", b, 0, 512);
        set_job(1, -8, 7);
        wait_jobs(b + 2, 100);
        chk_res("t6_min", b + 1, 1, -448);
        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
